// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4:1 multiplexer datapath.
// One requester is granted at a time. Its word is forwarded downstream over a
// valid/ready handshake. Each grant is capped at MAX_BURST beats so the other
// requesters are guaranteed a turn.
module mux4_rr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           req,
   input  logic [4*WIDTH-1:0]   data_in,
   input  logic                 out_ready,
   output logic [3:0]           gnt,
   output logic [1:0]           select,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic                 busy
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [3:0]      gnt_next;
   logic [1:0]      select_next;
   logic [1:0]      ptr;
   logic [1:0]      ptr_next;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_next;
   logic [CW-1:0]   cnt_inc;

   logic [WIDTH-1:0] words [4];
   logic [7:0]       req_dbl;
   logic [3:0]       req_rot;
   logic [1:0]       offset;
   logic [1:0]       pick;
   logic             transfer;

   // Unpack the requester words so the shared mux is a plain array index.
   for (genvar g = 0; g < 4; g++) begin : g_words
      assign words[g] = data_in[g*WIDTH +: WIDTH];
   end

   // Rotate the request vector so bit 0 is the requester at the pointer;
   // the winner is then simply the lowest set bit of the rotated vector.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl[ptr +: 4];

   // Find the first requester at or after the pointer.
   always_comb begin
      offset = 2'd0;
      if (req_rot[0]) begin
         offset = 2'd0;
      end else if (req_rot[1]) begin
         offset = 2'd1;
      end else if (req_rot[2]) begin
         offset = 2'd2;
      end else if (req_rot[3]) begin
         offset = 2'd3;
      end
   end

   assign pick      = ptr + offset;
   assign busy      = (state == GRANT);
   assign out_valid = busy & req[select];
   assign out_data  = busy ? words[select] : '0;
   assign transfer  = out_valid & out_ready;
   assign cnt_inc   = cnt + 1'b1;

   // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
   always_comb begin
      state_next  = state;
      gnt_next    = gnt;
      select_next = select;
      ptr_next    = ptr;
      cnt_next    = cnt;
      unique case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               state_next  = GRANT;
               gnt_next    = 4'b0001 << pick;
               select_next = pick;
               cnt_next    = '0;
            end
         end
         GRANT: begin
            if (!req[select] || (transfer && (cnt_inc == LAST_BEAT))) begin
               state_next = IDLE;
               gnt_next   = 4'b0000;
               ptr_next   = select + 2'd1;
               cnt_next   = '0;
            end else if (transfer) begin
               cnt_next = cnt_inc;
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
            cnt_next   = '0;
         end
      endcase
   end

   // State register; reset clears everything so requester 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         gnt    <= 4'b0000;
         select <= 2'd0;
         ptr    <= 2'd0;
         cnt    <= '0;
      end else begin
         state  <= state_next;
         gnt    <= gnt_next;
         select <= select_next;
         ptr    <= ptr_next;
         cnt    <= cnt_next;
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios with fixed
// expectations plus randomized traffic compared against a behavioural model.
module tb_mux4_rr_arbiter;

   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;

   logic                clk;
   logic                rst;
   logic [3:0]          req;
   logic [4*WIDTH-1:0]  data_in;
   logic                out_ready;
   logic [3:0]          gnt;
   logic [1:0]          select;
   logic                out_valid;
   logic [WIDTH-1:0]    out_data;
   logic                busy;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] word [4];

   // Behavioural model: who holds the grant, the rotation start point, beats taken.
   bit m_busy = 0;
   int m_sel  = 0;
   int m_ptr  = 0;
   int m_cnt  = 0;

   mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (data_in),
      .out_ready (out_ready),
      .gnt       (gnt),
      .select    (select),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack the per-requester words onto the bus.
   always_comb begin
      data_in = '0;
      for (int i = 0; i < 4; i++) data_in[i*WIDTH +: WIDTH] = word[i];
   end

   function automatic logic [3:0] exp_gnt();
      return m_busy ? (4'b0001 << m_sel) : 4'b0000;
   endfunction

   function automatic logic exp_valid(input logic [3:0] r);
      return m_busy && r[m_sel];
   endfunction

   // Apply one clock edge of the arbitration rules to the model.
   task automatic model_edge(input logic [3:0] r, input logic rd);
      bit found;
      int idx;
      if (!m_busy) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (!found && r[idx]) begin
               found  = 1;
               m_busy = 1;
               m_sel  = idx;
               m_cnt  = 0;
            end
         end
      end else if (!r[m_sel]) begin
         m_busy = 0;
         m_ptr  = (m_sel + 1) % 4;
         m_cnt  = 0;
      end else if (rd) begin
         m_cnt++;
         if (m_cnt == MAX_BURST) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % 4;
            m_cnt  = 0;
         end
      end
   endtask

   // Drive inputs, take one edge, advance the model, settle past the edge.
   task automatic step(input logic [3:0] r, input logic rd);
      req       = r;
      out_ready = rd;
      @(posedge clk);
      model_edge(r, rd);
      #1;
   endtask

   // Pulse reset between edges and put the model back to its reset state.
   task automatic do_reset();
      req       = 4'b0000;
      out_ready = 1'b0;
      rst       = 1'b1;
      #2;
      m_busy = 0;
      m_sel  = 0;
      m_ptr  = 0;
      m_cnt  = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         step(4'b0000, 1'b1);
         checks++;
         if (gnt !== 4'b0000 || select !== 2'b00 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got gnt=%b sel=%b busy=%b valid=%b data=%h expected 0000/00/0/0/00",
                     gnt, select, busy, out_valid, out_data);
         end
      end
   endtask

   task automatic test_single();
      logic [3:0] exp_g [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
      int beats;
      do_reset();
      word[2] = 8'hA5;
      beats = 0;
      for (int c = 0; c < 6; c++) begin
         step(4'b0100, 1'b1);
         checks++;
         if (gnt !== exp_g[c]) begin
            errors++;
            $display("[TB] FAIL single_gnt[%0d]: got %b expected %b", c, gnt, exp_g[c]);
         end
         if (c < 4) begin
            checks++;
            if (select !== 2'b10 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
               errors++;
               $display("[TB] FAIL single_beat[%0d]: got sel=%b valid=%b data=%h expected 10/1/a5",
                        c, select, out_valid, out_data);
            end
         end
         if (out_valid && out_ready && gnt == 4'b0100 && c < 5) beats++;
      end
      checks++;
      if (beats !== 4) begin
         errors++;
         $display("[TB] FAIL single_beat_count: got %0d expected 4", beats);
      end
   endtask

   task automatic test_rotate();
      logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] seen [$];
      logic [3:0] prev;
      int beats;
      do_reset();
      for (int i = 0; i < 4; i++) word[i] = 8'h10 + 8'(i);
      prev  = 4'b0000;
      beats = 0;
      for (int c = 0; c < 25; c++) begin
         step(4'b1111, 1'b1);
         if (gnt != 4'b0000 && prev == 4'b0000) seen.push_back(gnt);
         if (gnt != 4'b0000 && out_valid && out_ready) beats++;
         prev = gnt;
         checks++;
         if (gnt !== exp_gnt() || out_valid !== exp_valid(4'b1111)) begin
            errors++;
            $display("[TB] FAIL rotate_model[%0d]: got gnt=%b valid=%b expected %b/%b",
                     c, gnt, out_valid, exp_gnt(), exp_valid(4'b1111));
         end
      end
      checks++;
      if (seen.size() !== 5) begin
         errors++;
         $display("[TB] FAIL rotate_count: got %0d grants expected 5", seen.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (seen[i] !== exp_seq[i]) begin
               errors++;
               $display("[TB] FAIL rotate_order[%0d]: got %b expected %b", i, seen[i], exp_seq[i]);
            end
         end
      end
      checks++;
      if (beats !== 20) begin
         errors++;
         $display("[TB] FAIL rotate_beats: got %0d expected 20", beats);
      end
   endtask

   task automatic test_backpressure();
      logic       rdy   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0] exp_g [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
      do_reset();
      word[1] = 8'h3C;
      for (int c = 0; c < 7; c++) begin
         step(4'b0010, rdy[c]);
         checks++;
         if (gnt !== exp_g[c] || gnt !== exp_gnt()) begin
            errors++;
            $display("[TB] FAIL backpressure_gnt[%0d]: got %b expected %b", c, gnt, exp_g[c]);
         end
      end
   endtask

   task automatic test_early_drop();
      do_reset();
      word[0] = 8'h11;
      word[1] = 8'h22;
      for (int c = 0; c < 3; c++) step(4'b0011, 1'b1);
      checks++;
      if (gnt !== 4'b0001 || out_data !== 8'h11) begin
         errors++;
         $display("[TB] FAIL drop_before: got gnt=%b data=%h expected 0001/11", gnt, out_data);
      end
      req = 4'b0010;
      #1;
      checks++;
      if (out_valid !== 1'b0 || gnt !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL drop_cycle: got valid=%b gnt=%b expected 0/0001", out_valid, gnt);
      end
      step(4'b0010, 1'b1);
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drop_release: got gnt=%b busy=%b expected 0000/0", gnt, busy);
      end
      step(4'b0011, 1'b1);
      checks++;
      if (gnt !== 4'b0010 || select !== 2'b01 || out_data !== 8'h22) begin
         errors++;
         $display("[TB] FAIL drop_next: got gnt=%b sel=%b data=%h expected 0010/01/22", gnt, select, out_data);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int c = 0; c < 3; c++) step(4'b1000, 1'b1);
      checks++;
      if (select !== 2'b11 || m_cnt != 2 || out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL areset_setup: got sel=%b valid=%b expected 11/1", select, out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL areset_immediate: got gnt=%b busy=%b valid=%b expected 0000/0/0", gnt, busy, out_valid);
      end
      m_busy = 0;
      m_sel  = 0;
      m_ptr  = 0;
      m_cnt  = 0;
      @(negedge clk);
      rst = 1'b0;
      step(4'b1001, 1'b1);
      checks++;
      if (gnt !== 4'b0001 || select !== 2'b00) begin
         errors++;
         $display("[TB] FAIL areset_first: got gnt=%b sel=%b expected 0001/00", gnt, select);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic       rd;
      do_reset();
      r = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         rd = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 4; i++) word[i] = 8'($urandom);
         step(r, rd);
         checks++;
         if (gnt !== exp_gnt() || busy !== m_busy || out_valid !== exp_valid(r)) begin
            errors++;
            $display("[TB] FAIL random_ctrl[%0d]: got gnt=%b busy=%b valid=%b expected %b/%b/%b",
                     c, gnt, busy, out_valid, exp_gnt(), m_busy, exp_valid(r));
         end
         if (m_busy) begin
            checks++;
            if (select !== 2'(m_sel) || out_data !== word[m_sel]) begin
               errors++;
               $display("[TB] FAIL random_data[%0d]: got sel=%0d data=%h expected %0d/%h",
                        c, select, out_data, m_sel, word[m_sel]);
            end
         end
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      rst       = 1'b1;
      req       = 4'b0000;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) word[i] = '0;
      #12;
      test_reset();
      test_single();
      test_rotate();
      test_backpressure();
      test_early_drop();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4:1 multiplexer datapath.
- Four requesters each present a request and a data word. The block grants one requester at a time and drives the mux select.
- Forwards the selected word downstream with a valid/ready handshake.
- Bounds each grant to MAX_BURST transfers so that no requester can starve the others.

Parameters:
WIDTH, 8, data word width per requester
MAX_BURST, 4, maximum transfers per grant before forced rotation (legal range >= 1)

Ports:
clk  input  1  single clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
req  input  4  request per requester; bit i = requester i
data_in  input  4*WIDTH  packed requester words; requester i at [i*WIDTH +: WIDTH]
out_ready  input  1  downstream accepts out_data this cycle
gnt  output  4  one-hot grant, or 0 when no requester is granted
select  output  2  encoded index of the granted requester; drives the shared 4:1 mux
out_valid  output  1  out_data is valid
out_data  output  WIDTH  selected requester word
busy  output  1  high while in GRANT state

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high. All state is cleared immediately on rst assertion, independent of clk.
- Reset values:
  - state = IDLE; gnt = 0000; select = 00; busy = 0; out_valid = 0; out_data = 0.
  - Rotation pointer ptr = 0, so requester 0 has first priority after reset.
  - Beat counter cnt = 0.
- Registered state: state (IDLE, GRANT), gnt, select, ptr (2 bits), cnt (width clog2(MAX_BURST+1)).
- IDLE:
  - If req == 0000, remain in IDLE.
  - Otherwise pick the first i with req[i] = 1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At that edge: gnt = one-hot(i), select = i, cnt = 0, state = GRANT.
- Grant latency: a req sampled high at edge k in IDLE produces gnt, select and busy valid after edge k.
- GRANT outputs (combinational from registered state and inputs):
  - out_valid = req[select].
  - out_data = data_in[select], using the same selection as the 4:1 mux.
  - When out_valid = 0, out_data still equals data_in[select]; its value is don't-care downstream.
- Transfer: a beat transfers on any edge where out_valid && out_ready; on that edge cnt increments.
- Release conditions in GRANT, evaluated each edge:
  - (a) req[select] == 0, or
  - (b) a beat transfers and cnt+1 == MAX_BURST.
  - On release: gnt = 0000, busy = 0, ptr = select+1 (mod 4), cnt = 0, state = IDLE.
- Arbitration gap: there is exactly one IDLE cycle between consecutive grants. The peak per-requester rate is therefore MAX_BURST beats per MAX_BURST+1 cycles, with out_ready held high.
- Stability: select and gnt are constant for the whole GRANT interval.
- Backpressure: when out_valid=1 and out_ready=0, cnt is frozen and the grant is held. Requesters must hold data_in stable while their beat is pending.
- Simultaneous events:
  - Beat on the MAX_BURST-th transfer while other requests are pending: release and rotate. The next grant goes to the next requesting index after select, even if the current requester still requests.
  - A lone requester is re-granted after the one-cycle gap.
- Requests from requesters that are not granted have no effect during GRANT.
- Reset mid-operation: outputs return to reset values immediately on rst assertion. No partial beat is counted. ptr returns to 0.
- Wrap-around: ptr and select wrap 3 -> 0; cnt never exceeds MAX_BURST-1 in the registered state.

Test Plan:
- After reset with req=0000 for 5 cycles -> gnt=0000, select=00, busy=0, out_valid=0 throughout.
- req=0100, data_in[2]=8'hA5, out_ready=1, MAX_BURST=4:
  - gnt=0100 and select=10 one edge after req is sampled.
  - 4 beats of 8'hA5, then 1 IDLE cycle with gnt=0000, then re-grant of 0100.
- req=1111 held, out_ready=1:
  - Grants rotate 0001, 0010, 0100, 1000, 0001.
  - Each grant carries 4 beats, with 1 gap cycle between grants.
- req=0010, out_ready toggling 1,0,0,1,1,1:
  - cnt freezes on the ready=0 cycles and gnt is held.
  - Release occurs after the 4th transfer (edge 6), not before.
- Early drop with req=0011: requester 0 granted; req[0] drops after 2 beats.
  - Release on the next edge, with out_valid=0 during the drop cycle.
  - Next grant goes to requester 1 (select=01).
- rst asserted asynchronously mid-grant (select=11, cnt=2):
  - gnt=0000, busy=0, out_valid=0 immediately.
  - After release with req=1001, requester 0 is granted first (ptr=0).
